// File: rtl/spi_fifo_evt_gen.sv
// FIFO-threshold event generator for the SPI master: one interrupt FSM per FIFO channel,
// with re-arm by transfer count or by status read, pulse or level output, and sticky status.
module spi_fifo_evt_gen #(
  parameter int                NUM_CH    = 2,
  parameter int                CNT_WIDTH = 5,
  parameter logic [NUM_CH-1:0] CH_DIR    = 2'b10
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          clr_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   elements_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   th_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   cnt_i,
  input  logic [NUM_CH-1:0]             xfer_i,
  input  logic [NUM_CH-1:0]             int_en_i,
  input  logic [NUM_CH-1:0]             cnt_en_i,
  input  logic [NUM_CH-1:0]             pulse_mode_i,
  input  logic                          rd_sta_i,
  output logic [NUM_CH-1:0]             int_o,
  output logic [NUM_CH-1:0]             status_o,
  output logic                          event_o
);

  typedef enum logic [1:0] {
    ST_ACTIVE   = 2'd0,
    ST_GEN      = 2'd1,
    ST_INACTIVE = 2'd2
  } state_t;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_WIDTH-1:0] elem, th, cnt, cnt_last;
    logic [CNT_WIDTH-1:0] counter_q, counter_d;
    state_t               state_q, state_d;
    logic                 cond, hit;
    logic                 int_q, int_d;
    logic                 sta_q, sta_d;

    assign elem     = elements_i[k*CNT_WIDTH +: CNT_WIDTH];
    assign th       = th_i[k*CNT_WIDTH +: CNT_WIDTH];
    assign cnt      = cnt_i[k*CNT_WIDTH +: CNT_WIDTH];
    // A programmed count of zero behaves as one: re-arm on every transfer.
    assign cnt_last = (cnt == '0) ? '0 : cnt - 1'b1;
    assign cond     = CH_DIR[k] ? (elem >= th) : (elem <= th);
    assign hit      = cnt_en_i[k] && xfer_i[k] && (counter_q == cnt_last);

    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_ACTIVE:   if (int_en_i[k] && cond) state_d = ST_GEN;
        ST_GEN:      state_d = ST_INACTIVE;
        ST_INACTIVE: if (cnt_en_i[k] ? hit : rd_sta_i) state_d = ST_ACTIVE;
        default:     state_d = ST_ACTIVE;
      endcase
      if (clr_i) state_d = ST_ACTIVE;

      counter_d = counter_q;
      if (clr_i || !cnt_en_i[k]) counter_d = '0;
      else if (xfer_i[k])        counter_d = hit ? '0 : counter_q + 1'b1;

      // Output is registered alongside the state so no input reaches int_o combinationally.
      int_d = pulse_mode_i[k] ? (state_d == ST_GEN) : (state_d != ST_ACTIVE);

      sta_d = sta_q;
      if (clr_i)                  sta_d = 1'b0;
      else if (state_q == ST_GEN) sta_d = 1'b1;
      else if (rd_sta_i)          sta_d = 1'b0;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
        state_q   <= ST_ACTIVE;
        counter_q <= '0;
        int_q     <= 1'b0;
        sta_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        counter_q <= counter_d;
        int_q     <= int_d;
        sta_q     <= sta_d;
      end
    end

    assign int_o[k]    = int_q;
    assign status_o[k] = sta_q;
  end

  assign event_o = |int_o;

endmodule

// File: tb/tb_spi_fifo_evt_gen.sv
// Bench for spi_fifo_evt_gen: directed scenarios plus randomized traffic, compared against
// an armed/fired/waiting behavioural model of each channel.
module tb_spi_fifo_evt_gen;
  localparam int          NUM_CH = 2;
  localparam int          W      = 5;
  localparam int          VW     = NUM_CH * W;
  localparam logic [1:0]  DIR    = 2'b10;

  logic HCLK = 1'b0;
  logic HRESET, clr, rd_sta;
  logic [VW-1:0] elements, th, cnt;
  logic [NUM_CH-1:0] xfer, int_en, cnt_en, pulse_mode;
  logic [NUM_CH-1:0] int_o, status_o;
  logic event_o;

  int errors = 0;
  int checks = 0;

  // Model: armed = may fire; just_fired = fired last edge; neither = waiting for re-arm.
  bit m_armed [NUM_CH];
  bit m_just  [NUM_CH];
  int m_cnt   [NUM_CH];
  logic [NUM_CH-1:0] m_sta, m_int;

  spi_fifo_evt_gen #(.NUM_CH(NUM_CH), .CNT_WIDTH(W), .CH_DIR(DIR)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .clr_i(clr),
    .elements_i(elements), .th_i(th), .cnt_i(cnt),
    .xfer_i(xfer), .int_en_i(int_en), .cnt_en_i(cnt_en),
    .pulse_mode_i(pulse_mode), .rd_sta_i(rd_sta),
    .int_o(int_o), .status_o(status_o), .event_o(event_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_armed[k] = 1'b1;
      m_just[k]  = 1'b0;
      m_cnt[k]   = 0;
    end
    m_sta = '0;
    m_int = '0;
  endtask

  task automatic model_update();
    int e, t, c, period;
    bit cond, hit, fire, rearm;
    logic [NUM_CH-1:0] sta_n, int_n;
    for (int k = 0; k < NUM_CH; k++) begin
      e = int'(elements[k*W +: W]);
      t = int'(th[k*W +: W]);
      c = int'(cnt[k*W +: W]);
      period = (c == 0) ? 1 : c;
      cond = DIR[k] ? (e >= t) : (e <= t);
      hit  = cnt_en[k] && xfer[k] && (m_cnt[k] == period - 1);
      if (clr) begin
        m_armed[k] = 1'b1;
        m_just[k]  = 1'b0;
        m_cnt[k]   = 0;
        sta_n[k]   = 1'b0;
        int_n[k]   = 1'b0;
      end else begin
        sta_n[k] = m_just[k] ? 1'b1 : (rd_sta ? 1'b0 : m_sta[k]);
        fire  = m_armed[k] && int_en[k] && cond;
        rearm = !m_armed[k] && !m_just[k] && (cnt_en[k] ? hit : rd_sta);
        if (!cnt_en[k])   m_cnt[k] = 0;
        else if (xfer[k]) m_cnt[k] = hit ? 0 : (m_cnt[k] + 1) % (1 << W);
        m_armed[k] = m_armed[k] ? !fire : rearm;
        m_just[k]  = fire;
        int_n[k]   = pulse_mode[k] ? fire : !m_armed[k];
      end
    end
    m_sta = sta_n;
    m_int = int_n;
  endtask

  task automatic cycle();
    @(posedge HCLK);
    model_update();
    #1;
  endtask

  task automatic setup();
    elements = '0; th = '0; cnt = '0;
    xfer = '0; int_en = '0; cnt_en = '0; pulse_mode = '0; rd_sta = 1'b0;
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({event_o, status_o, int_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got ev/sta/int=%b/%b/%b want 0/00/00", event_o, status_o, int_o);
    end
  endtask

  task automatic test_tx_threshold();
    setup();
    int_en = 2'b01; pulse_mode = 2'b01; th[0 +: W] = 5'd2; elements[0 +: W] = 5'd5;
    cycle();
    checks++;
    if (int_o !== 2'b00) begin
      errors++; $display("FAIL tx_above_th: got int=%b want 00", int_o);
    end
    elements[0 +: W] = 5'd2;
    cycle();
    checks++;
    if ({event_o, status_o[0], int_o[0]} !== 3'b101) begin
      errors++; $display("FAIL tx_fire: got ev/sta/int=%b/%b/%b want 1/0/1", event_o, status_o[0], int_o[0]);
    end
    cycle();
    checks++;
    if ({event_o, status_o[0], int_o[0]} !== 3'b010) begin
      errors++; $display("FAIL tx_after_pulse: got ev/sta/int=%b/%b/%b want 0/1/0", event_o, status_o[0], int_o[0]);
    end
  endtask

  task automatic test_rx_count_rearm();
    setup();
    int_en = 2'b10; pulse_mode = 2'b10; cnt_en = 2'b10;
    th[W +: W] = 5'd4; cnt[W +: W] = 5'd3; elements[W +: W] = 5'd4;
    cycle();
    checks++;
    if (int_o[1] !== 1'b1) begin
      errors++; $display("FAIL rx_fire: got int1=%b want 1", int_o[1]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (int_o[1] !== 1'b0) begin
        errors++; $display("FAIL rx_hold_no_refire: cycle %0d got int1=%b want 0", i, int_o[1]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      xfer[1] = 1'b1;
      cycle();
      xfer[1] = 1'b0;
      checks++;
      if (int_o[1] !== 1'b0) begin
        errors++; $display("FAIL rx_xfer_wait: strobe %0d got int1=%b want 0", i, int_o[1]);
      end
    end
    cycle();
    checks++;
    if (int_o[1] !== 1'b1) begin
      errors++; $display("FAIL rx_refire: got int1=%b want 1", int_o[1]);
    end
  endtask

  task automatic test_level_rdsta();
    setup();
    int_en = 2'b01; th[0 +: W] = 5'd3; elements[0 +: W] = 5'd1;
    for (int c = 1; c <= 9; c++) begin
      cycle();
      checks++;
      if (int_o[0] !== 1'b1) begin
        errors++; $display("FAIL level_hold: cycle %0d got int0=%b want 1", c, int_o[0]);
      end
    end
    rd_sta = 1'b1;
    cycle();
    rd_sta = 1'b0;
    checks++;
    if ({status_o[0], int_o[0]} !== 2'b00) begin
      errors++; $display("FAIL level_rd_clear: got sta0/int0=%b/%b want 0/0", status_o[0], int_o[0]);
    end
    cycle();
    checks++;
    if (int_o[0] !== 1'b1) begin
      errors++; $display("FAIL level_refire: got int0=%b want 1", int_o[0]);
    end
  endtask

  task automatic test_cnt_zero();
    int pulses = 0;
    setup();
    int_en = 2'b10; pulse_mode = 2'b10; cnt_en = 2'b10;
    th[W +: W] = 5'd4; elements[W +: W] = 5'd7; cnt[W +: W] = 5'd0;
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      xfer[1] = 1'b1;
      cycle();
      xfer[1] = 1'b0;
      if (int_o[1]) pulses++;
      for (int j = 0; j < 2; j++) begin
        cycle();
        if (int_o[1]) pulses++;
        checks++;
        if ({event_o, status_o, int_o} !== {|m_int, m_sta, m_int}) begin
          errors++; $display("FAIL cnt_zero_model: got sta/int=%b/%b want %b/%b", status_o, int_o, m_sta, m_int);
        end
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL cnt_zero_pulses: got %0d want 4", pulses);
    end
  endtask

  task automatic test_rd_same_gen();
    setup();
    int_en = 2'b01; pulse_mode = 2'b01; th[0 +: W] = 5'd2; elements[0 +: W] = 5'd9;
    cycle();
    elements[0 +: W] = 5'd0;
    cycle();
    rd_sta = 1'b1;
    cycle();
    rd_sta = 1'b0;
    checks++;
    if ({status_o[0], int_o[0]} !== 2'b10) begin
      errors++; $display("FAIL rd_in_gen: got sta0/int0=%b/%b want 1/0", status_o[0], int_o[0]);
    end
    cycle();
    checks++;
    if ({status_o[0], int_o[0]} !== 2'b10) begin
      errors++; $display("FAIL rd_in_gen_no_rearm: got sta0/int0=%b/%b want 1/0", status_o[0], int_o[0]);
    end
  endtask

  task automatic test_clr();
    setup();
    int_en = 2'b10; pulse_mode = 2'b10; cnt_en = 2'b10;
    th[W +: W] = 5'd4; cnt[W +: W] = 5'd3; elements[W +: W] = 5'd4;
    cycle();
    cycle();
    for (int i = 0; i < 2; i++) begin
      xfer[1] = 1'b1; cycle(); xfer[1] = 1'b0;
    end
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    checks++;
    if ({status_o[1], int_o[1]} !== 2'b00) begin
      errors++; $display("FAIL clr_state: got sta1/int1=%b/%b want 0/0", status_o[1], int_o[1]);
    end
    cycle();
    checks++;
    if (int_o[1] !== 1'b1) begin
      errors++; $display("FAIL clr_refire: got int1=%b want 1", int_o[1]);
    end
    for (int i = 0; i < 3; i++) begin
      xfer[1] = 1'b1; cycle(); xfer[1] = 1'b0;
      cycle();
      checks++;
      if (int_o[1] !== (i == 2)) begin
        errors++; $display("FAIL clr_counter_zeroed: strobe %0d got int1=%b want %b", i, int_o[1], (i == 2));
      end
    end
  endtask

  task automatic test_random();
    setup();
    cnt = {5'd2, 5'd3};
    for (int n = 0; n < 600; n++) begin
      elements = VW'($urandom);
      if ($urandom_range(0, 7) == 0) th = VW'($urandom);
      if ($urandom_range(0, 15) == 0) cnt = VW'({$urandom_range(0, 4), 5'($urandom_range(0, 4))});
      xfer       = NUM_CH'($urandom);
      int_en     = ($urandom_range(0, 5) == 0) ? NUM_CH'($urandom) : 2'b11;
      if ($urandom_range(0, 31) == 0) cnt_en     = NUM_CH'($urandom);
      if ($urandom_range(0, 31) == 0) pulse_mode = NUM_CH'($urandom);
      rd_sta     = ($urandom_range(0, 7) == 0);
      clr        = ($urandom_range(0, 49) == 0);
      cycle();
      checks++;
      if ({event_o, status_o, int_o} !== {|m_int, m_sta, m_int}) begin
        errors++;
        $display("FAIL random_%0d: got ev/sta/int=%b/%b/%b want %b/%b/%b", n,
                 event_o, status_o, int_o, |m_int, m_sta, m_int);
      end
    end
    clr = 1'b0; rd_sta = 1'b0; xfer = '0;
  endtask

  task automatic test_async_reset();
    setup();
    int_en = 2'b11; cnt_en = 2'b10; cnt[W +: W] = 5'd3;
    th = {5'd1, 5'd31};
    elements = {5'd8, 5'd0};
    xfer = 2'b10;
    cycle();
    checks++;
    if (int_o !== 2'b11) begin
      errors++; $display("FAIL pre_reset_level: got int=%b want 11", int_o);
    end
    #2 HRESET = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({event_o, status_o, int_o} !== 5'b0) begin
      errors++; $display("FAIL async_reset: got ev/sta/int=%b/%b/%b want 0/00/00", event_o, status_o, int_o);
    end
    #3 HRESET = 1'b0;
    xfer = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({event_o, status_o, int_o} !== {|m_int, m_sta, m_int}) begin
        errors++; $display("FAIL post_reset_%0d: got sta/int=%b/%b want %b/%b", i, status_o, int_o, m_sta, m_int);
      end
    end
  endtask

  initial begin
    HRESET = 1'b1; clr = 1'b0; rd_sta = 1'b0;
    elements = '0; th = '0; cnt = '0;
    xfer = '0; int_en = '0; cnt_en = '0; pulse_mode = '0;
    model_reset();
    #12;
    test_reset();
    HRESET = 1'b0;
    test_tx_threshold();
    test_rx_count_rearm();
    test_level_rdsta();
    test_cnt_zero();
    test_rd_same_gen();
    test_clr();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
